pa_core_param: RTL and testbench

- Parametrised successor to the fixed 4x4 processing-array top.
- Holds an internal int8 weight store and streams int8 activation vectors over a single shared input bus.
- Computes OCH dot products of length K*LANES per vector, then requantises each to int8 with a rounding shift, saturation and optional ReLU.
- Emits one packed OCH-byte result per vector over a valid/ready output.
- Adds weight reuse (skip reload), an output-register backpressure stall and a drain/done phase.

---
 rtl/pa_core_param.sv | 137 +++++++++++++
 tb/tb_pa_core_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_core_param.sv
// pa_core_param: parametrised int8 processing array with internal weight store and requantised output
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, cfg_*                job start and configuration (latched in IDLE)
//   in_data/in_valid/in_ready   shared weight/activation input stream
//   out_data/out_valid/out_ready packed OCH-byte result stream
//   state, busy, done           FSM state, non-idle flag, end-of-job pulse
module pa_core_param #(
    parameter int LANES = 4,
    parameter int OCH   = 4,
    parameter int KMAX  = 128,
    parameter int ACC_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(KMAX+1)-1:0]  cfg_k_len,
    input  logic [15:0]                cfg_n_vec,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_relu,
    input  logic                       cfg_load_w,
    input  logic [LANES*8-1:0]         in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [OCH*8-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 state,
    output logic                       busy,
    output logic                       done
);
    localparam int KW = $clog2(KMAX+1);
    localparam int WI = $clog2(KMAX*OCH);
    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;
    state_t                  r_state;
    logic [KW-1:0]           r_k_len, r_k;
    logic [15:0]             r_n_vec, r_n;
    logic [4:0]              r_shift;
    logic                    r_relu, r_valid, r_done;
    logic [WI-1:0]           r_widx;
    logic [OCH*8-1:0]        r_out;
    logic signed [ACC_W-1:0] r_acc [OCH];
    logic [LANES*8-1:0]      r_w [KMAX*OCH];
    logic signed [ACC_W-1:0] w_sum [OCH];
    logic signed [ACC_W:0]   w_r, w_q, w_rnd;
    logic signed [15:0]      w_p;
    logic [OCH*8-1:0]        w_pack;
    logic [KW-1:0]           w_k_eff;
    logic                    w_klast, w_wlast, w_fire;

    assign w_k_eff  = cfg_k_len > KW'(KMAX) ? KW'(KMAX) : cfg_k_len;
    assign w_klast  = int'(r_k) == int'(r_k_len) - 1;
    assign w_wlast  = int'(r_widx) == int'(r_k_len) * OCH - 1;
    // only the closing beat of a vector waits, and only while the previous result is still held
    assign in_ready = r_state == LOAD_W || (r_state == COMPUTE && !(w_klast && r_valid && !out_ready));
    assign w_fire   = in_valid && in_ready;
    // half-LSB rounding constant; evaluates to zero when shift is zero
    assign w_rnd    = (ACC_W+1)'(1) << r_shift >> 1;

    always_comb begin
        w_p    = '0;
        w_r    = '0;
        w_q    = '0;
        w_pack = '0;
        for (int o = 0; o < OCH; o++) begin
            w_sum[o] = r_acc[o];
            for (int i = 0; i < LANES; i++) begin
                w_p      = $signed(in_data[i*8+:8]) * $signed(r_w[WI'(int'(r_k) * OCH + o)][i*8+:8]);
                w_sum[o] = w_sum[o] + ACC_W'(w_p);
            end
            // one guard bit so the rounding add cannot wrap
            w_r = {w_sum[o][ACC_W-1], w_sum[o]};
            w_q = (w_r + w_rnd) >>> r_shift;
            w_pack[o*8+:8] = w_q > 127 ? 8'h7f : (r_relu && w_q < 0) ? 8'h00 : w_q < -128 ? 8'h80 : w_q[7:0];
        end
    end

    // weight store is deliberately outside the reset domain so reuse survives a reset
    always_ff @(posedge clk)
        if (r_state == LOAD_W && in_valid) r_w[r_widx] <= in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k_len <= '0;
            r_n_vec <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_k     <= '0;
            r_n     <= '0;
            r_widx  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            for (int o = 0; o < OCH; o++) r_acc[o] <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_valid && out_ready) r_valid <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_k_len <= w_k_eff;
                    r_n_vec <= cfg_n_vec;
                    r_shift <= cfg_shift;
                    r_relu  <= cfg_relu;
                    r_k     <= '0;
                    r_n     <= '0;
                    r_widx  <= '0;
                    r_state <= (w_k_eff == '0 || cfg_n_vec == '0) ? DRAIN : cfg_load_w ? LOAD_W : COMPUTE;
                end
                LOAD_W: if (in_valid) begin
                    r_widx <= w_wlast ? '0 : r_widx + WI'(1);
                    if (w_wlast) r_state <= COMPUTE;
                end
                COMPUTE: if (w_fire) begin
                    r_k <= w_klast ? '0 : r_k + KW'(1);
                    for (int o = 0; o < OCH; o++) r_acc[o] <= w_klast ? '0 : w_sum[o];
                    if (w_klast) begin
                        r_out   <= w_pack;
                        r_valid <= 1'b1;
                        r_n     <= r_n + 16'd1;
                        if (r_n == r_n_vec - 16'd1) r_state <= DRAIN;
                    end
                end
                DRAIN: if (!r_valid) begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_valid;
    assign state     = r_state;
    assign busy      = r_state != IDLE;
    assign done      = r_done;
endmodule

// File: tb/tb_pa_core_param.sv
// tb_pa_core_param: randomized scoreboard bench for pa_core_param against a dot-product reference model
module tb_pa_core_param;
    localparam int LANES = 4, OCH = 4, KMAX = 128, ACC_W = 32;
    localparam int KW = $clog2(KMAX+1);

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [KW-1:0] cfg_k_len = '0;
    logic [15:0] cfg_n_vec = '0;
    logic [4:0] cfg_shift = '0;
    logic cfg_relu = 1'b0, cfg_load_w = 1'b0;
    logic [LANES*8-1:0] in_data = '0;
    logic in_valid = 1'b0, in_ready;
    logic [OCH*8-1:0] out_data;
    logic out_valid, out_ready = 1'b1;
    logic [1:0] state;
    logic busy, done;

    pa_core_param #(.LANES(LANES), .OCH(OCH), .KMAX(KMAX), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_k_len(cfg_k_len), .cfg_n_vec(cfg_n_vec),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_load_w(cfg_load_w), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .state(state), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0, hs_first = -1, hs_last = -1;
    int stalls = 0, ready_hold = 0;
    bit rnd_ready = 1'b0, saw_load = 1'b0;
    int tw [KMAX][OCH][LANES];
    int act [KMAX][LANES];
    logic [OCH*8-1:0] q [$];

    task automatic chk(string name, logic [63:0] a, logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, a, e, cyc);
        end
    endtask

    function automatic int wgen(int m, int o);
        byte b;
        b = byte'($urandom);
        return m == 0 ? int'(b) : m == 1 ? o + 1 : m == 2 ? 1 : 127;
    endfunction

    function automatic int agen(int m, int k, int i);
        byte b;
        b = byte'($urandom);
        return m == 0 ? int'(b) : m == 1 ? i + 1 : m == 2 ? ((k == 1 && i == 3) ? 2 : 1) : m == 3 ? 127 : -127;
    endfunction

    function automatic logic [7:0] rq(longint r, int sh, bit relu);
        longint v, lo;
        v  = sh > 0 ? (r + (longint'(1) << (sh - 1))) >>> sh : r;
        lo = relu ? 0 : -128;
        if (v > 127) v = 127;
        if (v < lo) v = lo;
        return v[7:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (ready_hold > 0) begin
            out_ready = 1'b0;
            ready_hold--;
        end else out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (state == 2'd1) saw_load = 1'b1;
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h with no result expected", out_data);
            end else chk("out_data", out_data, q.pop_front());
            hs_last = cyc;
            if (hs_first < 0) hs_first = cyc;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(logic [LANES*8-1:0] d, bit gaps);
        int t = 0;
        logic r;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        in_data  = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            r = in_ready;
            if (!r) stalls++;
            @(posedge clk);
            #1;
            if (r) break;
            if (++t > 2000) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_job(int kc, int n, int sh, bit relu, bit ld, int wm, int dm, bit gaps, bit cchk, logic [31:0] cval);
        int ke, d0, t;
        bit empty;
        logic [LANES*8-1:0] w;
        logic [OCH*8-1:0] e;
        longint r;
        ke = kc > KMAX ? KMAX : kc;
        empty = ke == 0 || n == 0;
        stalls = 0;
        hs_first = -1;
        saw_load = 1'b0;
        d0 = done_cnt;
        cfg_k_len = KW'(kc);
        cfg_n_vec = 16'(n);
        cfg_shift = 5'(sh);
        cfg_relu = relu;
        cfg_load_w = ld;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_k_len = KW'($urandom);
        cfg_n_vec = 16'($urandom);
        cfg_shift = 5'($urandom);
        cfg_relu = 1'($urandom);
        cfg_load_w = 1'($urandom);
        chk("busy_after_start", busy, 1);
        chk("state_after_start", state, empty ? 3 : ld ? 1 : 2);
        if (empty) begin
            @(posedge clk);
            #1;
            chk("empty_done", done, 1);
            chk("empty_no_out", out_valid, 0);
        end else begin
            if (ld) for (int b = 0; b < ke * OCH; b++) begin
                for (int i = 0; i < LANES; i++) begin
                    tw[b / OCH][b % OCH][i] = wgen(wm, b % OCH);
                    w[i*8+:8] = 8'(tw[b / OCH][b % OCH][i]);
                end
                send_beat(w, gaps);
            end
            for (int v = 0; v < n; v++) begin
                for (int k = 0; k < ke; k++)
                    for (int i = 0; i < LANES; i++) act[k][i] = agen(dm, k, i);
                for (int o = 0; o < OCH; o++) begin
                    r = 0;
                    for (int k = 0; k < ke; k++)
                        for (int i = 0; i < LANES; i++) r += longint'(act[k][i]) * tw[k][o][i];
                    e[o*8+:8] = rq(r, sh, relu);
                end
                q.push_back(e);
                for (int k = 0; k < ke; k++) begin
                    for (int i = 0; i < LANES; i++) w[i*8+:8] = 8'(act[k][i]);
                    send_beat(w, gaps);
                end
                chk("latency_valid", out_valid, 1);
                if (cchk) chk("const_out", out_data, cval);
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: done never pulsed, expected one pulse");
        end
        @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("queue_empty", q.size(), 0);
        chk("load_visited", saw_load, ld && !empty);
        chk("idle_after_done", state, 0);
    endtask

    initial begin
        int d0;
        #23;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_job(1, 1, 0, 0, 1, 1, 1, 0, 1, 32'h281E140A);
        run_job(2, 1, 2, 0, 1, 2, 2, 0, 1, 32'h02020202);
        run_job(2, 1, 0, 0, 1, 3, 3, 0, 1, 32'h7F7F7F7F);
        run_job(2, 1, 0, 0, 0, 0, 4, 0, 1, 32'h80808080);
        run_job(2, 1, 0, 1, 0, 0, 4, 0, 1, 32'h00000000);
        run_job(200, 1, 6, 0, 1, 0, 0, 0, 0, 0);
        ready_hold = 6;
        run_job(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_stalled", stalls > 0, 1);
        ready_hold = 0;
        run_job(1, 3, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b_no_stall", stalls, 0);
        chk("b2b_rate", hs_last - hs_first, 2);
        rnd_ready = 1'b1;
        run_job(3, 2, 5, 0, 1, 0, 0, 1, 0, 0);
        run_job(3, 2, 5, 0, 0, 0, 0, 1, 0, 0);
        run_job(0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        run_job(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++)
            run_job($urandom_range(1, 8), $urandom_range(1, 4), $urandom_range(0, 12), 1'($urandom),
                    j == 0 ? 1'b1 : 1'($urandom), 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        cfg_k_len = KW'(4);
        cfg_n_vec = 16'd2;
        cfg_shift = 5'd3;
        cfg_relu = 1'b0;
        cfg_load_w = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) send_beat(LANES*8'($urandom), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_done", done, 0);
        q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt, d0);
        run_job(4, 3, 4, 1, 0, 0, 0, 1, 0, 0);
        run_job(4, 2, 2, 0, 0, 0, 0, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
